tick_serializer: RTL and testbench

Downstream consumer of the divide-by-2 clock stage. Accepts a parallel data word over a valid/ready handshake and shifts out one framed serial bit per `tick` (the divider's `newclk` pulse). The serial line feeds the modulator front end.
Frame format, in transmit order:
- preamble
- data, MSB first
- even-parity bit
- return to idle level

---
 rtl/mod_pkg.sv | 8 +
 rtl/parity_gen.sv | 11 +
 rtl/tick_serializer.sv | 82 ++++++++
 tb/tb_tick_serializer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mod_pkg.sv
// mod_pkg: shared state type and default parameters for the tick serializer
package mod_pkg;
    typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, TAIL} ser_state_t;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_PRE_LEN = 4;
    localparam logic [7:0] DEF_PRE_PAT = 8'b0000_1010;
    localparam logic DEF_IDLE_LVL = 1'b0;
endpackage

// File: rtl/parity_gen.sv
// parity_gen: combinational even parity (XOR of all bits) over W bits
//   data in  W  word to cover
//   par  out 1  1 when data holds an odd number of ones
module parity_gen #(
    parameter int W = 8
) (
    input  logic [W-1:0] data,
    output logic         par
);
    assign par = ^data;
endmodule

// File: rtl/tick_serializer.sv
// tick_serializer: frames a parallel word as preamble, data MSB first, even parity, one bit per tick
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   tick       in   bit-rate enable
//   in_data    in   payload word
//   in_valid   in   payload valid
//   in_ready   out  high in IDLE
//   tx_bit     out  registered serial bit
//   tx_active  out  registered, high while frame bits are on tx_bit
//   frame_done out  registered one-clk pulse after the parity bit period
module tick_serializer
    import mod_pkg::*;
#(
    parameter int         DATA_W   = DEF_DATA_W,
    parameter int         PRE_LEN  = DEF_PRE_LEN,
    parameter logic [7:0] PRE_PAT  = DEF_PRE_PAT,
    parameter logic       IDLE_LVL = DEF_IDLE_LVL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_active,
    output logic              frame_done
);
    localparam int CW = $clog2(PRE_LEN > DATA_W ? PRE_LEN : DATA_W) + 1;
    ser_state_t        state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_q;
    logic              in_par;
    parity_gen #(.W(DATA_W)) u_par (.data(in_data), .par(in_par));
    assign in_ready = state == IDLE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            par_q      <= 1'b0;
            tx_bit     <= IDLE_LVL;
            tx_active  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                // a tick in the accept cycle is deliberately not acted on
                IDLE: if (in_valid) begin
                    shreg <= in_data;
                    par_q <= in_par;
                    cnt   <= '0;
                    state <= PRE;
                end
                PRE: if (tick) begin
                    tx_bit    <= PRE_PAT[3'(PRE_LEN - 1 - int'(cnt))];
                    tx_active <= 1'b1;
                    cnt       <= cnt == CW'(PRE_LEN - 1) ? '0 : cnt + CW'(1);
                    state     <= cnt == CW'(PRE_LEN - 1) ? DATA : PRE;
                end
                DATA: if (tick) begin
                    tx_bit <= shreg[DATA_W-1];
                    shreg  <= {shreg[DATA_W-2:0], 1'b0};
                    cnt    <= cnt == CW'(DATA_W - 1) ? '0 : cnt + CW'(1);
                    state  <= cnt == CW'(DATA_W - 1) ? PAR : DATA;
                end
                PAR: if (tick) begin
                    tx_bit <= par_q;
                    state  <= TAIL;
                end
                TAIL: if (tick) begin
                    tx_bit     <= IDLE_LVL;
                    tx_active  <= 1'b0;
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tick_serializer.sv
// tb_tick_serializer: vector table, corner sequences and randomized frames against a frame model
module tb_tick_serializer;
    logic       clk = 1'b0;
    logic       rst_n, tick, in_valid;
    logic [7:0] in_data;
    logic       in_ready, tx_bit, tx_active, frame_done;
    int         checks = 0;
    int         passed = 0;

    tick_serializer dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx_bit(tx_bit), .tx_active(tx_active), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        int          gap;
        bit          tacc;
        bit          inj;
        bit          hold;
        logic [7:0]  nxt;
        logic [12:0] exp;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // frame built from the format rules: 4-bit preamble 1010, data MSB first, even parity
    function automatic logic [12:0] model(input logic [7:0] d);
        bit q[$];
        int ones = 0;
        logic [12:0] r = '0;
        logic [7:0] pat = 8'b0000_1010;
        for (int i = 3; i >= 0; i--) q.push_back(pat[i]);
        for (int i = 7; i >= 0; i--) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        q.push_back(bit'(ones % 2));
        for (int i = 0; i < 13; i++) r[12-i] = q[i];
        return r;
    endfunction

    task automatic run_frame(input logic [7:0] d, input int gap, input bit tacc, input bit inj,
                             input bit hold, input logic [7:0] nxt, input logic [12:0] exp,
                             input int abort_at);
        in_data  = d;
        in_valid = 1'b1;
        tick     = tacc;
        step();
        chk("accept_ready", in_ready, 0);
        chk("accept_active", tx_active, 0);
        chk("accept_bit", tx_bit, 0);
        chk("accept_done", frame_done, 0);
        in_valid = hold;
        in_data  = hold ? nxt : 8'($urandom);
        tick     = 1'b0;
        for (int i = 0; i < 14; i++) begin
            for (int g = 1; g < gap; g++) begin
                step();
                chk("hold_bit", tx_bit, i == 0 ? 1'b0 : exp[13-i]);
            end
            if (inj && i == 6) begin
                in_valid = 1'b1;
                in_data  = 8'hFF;
                chk("busy_ready", in_ready, 0);
            end
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (inj && i == 6) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            if (i < 13) begin
                chk($sformatf("bit%0d", i), tx_bit, exp[12-i]);
                chk("active", tx_active, 1);
                chk("no_done", frame_done, 0);
                chk("busy", in_ready, 0);
            end else begin
                chk("tail_bit", tx_bit, 0);
                chk("tail_active", tx_active, 0);
                chk("done", frame_done, 1);
                chk("done_ready", in_ready, 1);
            end
            if (i == abort_at) begin
                rst_n    = 1'b0;
                tick     = 1'b1;
                in_valid = 1'b1;
                step();
                chk("rst_bit", tx_bit, 0);
                chk("rst_active", tx_active, 0);
                chk("rst_done", frame_done, 0);
                chk("rst_ready", in_ready, 1);
                rst_n    = 1'b1;
                tick     = 1'b0;
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{8'hA5, 2, 1'b0, 1'b0, 1'b0, 8'h00, 13'b1010_1010_0101_0};
        vecs[1] = '{8'h01, 1, 1'b0, 1'b0, 1'b0, 8'h00, 13'b1010_0000_0001_1};
        vecs[2] = '{8'h3C, 2, 1'b0, 1'b1, 1'b0, 8'h00, 13'b1010_0011_1100_0};
        vecs[3] = '{8'h80, 2, 1'b0, 1'b0, 1'b1, 8'h7F, 13'b1010_1000_0000_1};
        vecs[4] = '{8'h7F, 2, 1'b0, 1'b0, 1'b0, 8'h00, 13'b1010_0111_1111_1};
        vecs[5] = '{8'hC3, 3, 1'b1, 1'b0, 1'b0, 8'h00, 13'b1010_1100_0011_0};
        vecs[6] = '{8'hFF, 1, 1'b1, 1'b0, 1'b0, 8'h00, 13'b1010_1111_1111_0};
        rst_n    = 1'b0;
        tick     = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) step();
        chk("reset_bit", tx_bit, 0);
        chk("reset_active", tx_active, 0);
        chk("reset_done", frame_done, 0);
        chk("reset_ready", in_ready, 1);
        rst_n    = 1'b1;
        tick     = 1'b0;
        in_valid = 1'b0;
        step();
        chk("idle_ready", in_ready, 1);
        for (int i = 0; i < 7; i++)
            run_frame(vecs[i].data, vecs[i].gap, vecs[i].tacc, vecs[i].inj, vecs[i].hold,
                      vecs[i].nxt, vecs[i].exp, -1);
        run_frame(8'hA5, 2, 1'b0, 1'b0, 1'b0, 8'h00, 13'b1010_1010_0101_0, 6);
        run_frame(8'hA5, 2, 1'b0, 1'b0, 1'b0, 8'h00, 13'b1010_1010_0101_0, -1);
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d = 8'($urandom);
            run_frame(d, int'($urandom_range(1, 3)), 1'($urandom), 1'b0, 1'b0, 8'h00, model(d), -1);
        end
        in_valid = 1'b0;
        repeat (2) step();
        chk("end_idle_bit", tx_bit, 0);
        chk("end_no_done", frame_done, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
